simple_bus_xbar: RTL and testbench
==================================

// Module: simple_bus_xbar
// PURPOSE
// Single-cycle, address-decoded interconnect joining N bus hosts to M memory-mapped devices.
// Each cycle it arbitrates among requesting hosts by fixed priority and decodes the winner's
// address against runtime base/mask registers. It forwards the request to one device and
// routes that device's response back to the originating host. Sits between core data port
// and RAM / sim-ctrl / timer.
// PARAMETERS
// NrDevices     1   number of device ports (>=1)
// NrHosts       1   number of host ports (>=1)
// DataWidth     32  data bus width; byte-enable width = DataWidth/8
// AddressWidth  32  address bus width
// PORTS (arrays are unpacked [NrHosts] / [NrDevices])
// clk_i                 in   1             clock
// rst_ni                in   1             asynchronous active-low reset
// host_req_i            in   1  x H        host request
// host_gnt_o            out  1  x H        grant, combinational, same cycle as req
// host_addr_i           in   AW x H        byte address
// host_we_i             in   1  x H        1=write
// host_be_i             in   DW/8 x H      byte enables
// host_wdata_i          in   DW x H        write data
// host_rvalid_o         out  1  x H        response valid
// host_rdata_o          out  DW x H        read data
// host_err_o            out  1  x H        response error
// device_req_o          out  1  x D        device request
// device_addr_o         out  AW x D        forwarded address
// device_we_o           out  1  x D        forwarded write enable
// device_be_o           out  DW/8 x D      forwarded byte enables
// device_wdata_o        out  DW x D        forwarded write data
// device_rvalid_i       in   1  x D        device response valid
// device_rdata_i        in   DW x D        device read data
// device_err_i          in   1  x D        device error
// cfg_device_addr_base  in   AW x D        device base address
// cfg_device_addr_mask  in   AW x D        device address mask
// BEHAVIOUR
// - Arbitration: fixed priority, lowest host index wins. host_gnt_o[h]=1 only for the winner,
//   in the same cycle. No back-pressure; a winner is always granted.
// - Decode: device d matches when (addr & mask[d]) == base[d]. Lowest matching index wins.
// - Forwarding: addr/we/be/wdata of the winning host go to all device ports.
//   device_req_o is 1 only for the matched device, and only when some host requests.
// - Unmapped address: grant is still given and no device_req. The next cycle drives
//   host_rvalid_o=1, host_err_o=1, host_rdata_o='0 to that host.
// - Response: devices respond exactly 1 cycle after req. On a grant, register the winning
//   host index, the device index (or unmapped flag) and a pending bit.
//   Next cycle, the registered host gets rvalid/rdata/err combinationally from the
//   registered device, and rvalid requires the pending bit.
// - Non-selected hosts: host_rvalid_o=0, host_err_o=0, host_rdata_o='0.
// - Throughput: back-to-back grants allowed every cycle, with the response of cycle n
//   arriving in cycle n+1.
// - Reset: pending=0, selections=0; all host_rvalid_o/host_err_o=0 and host_rdata_o='0
//   during and after reset until a new grant. Reset mid-transaction drops the response.
// - Widths: host/device select registers are $clog2 wide with min 1 bit.
// TESTING (map: RAM 0x100000/~0xFFFFF, SimCtrl 0x20000/~0x3FF, Timer 0x30000/~0x3FF)
// - Host0 read 0x100004, RAM returns 0xDEADBEEF -> gnt same cycle, device_req[0]=1,
//   next cycle host_rvalid=1, rdata=0xDEADBEEF, err=0.
// - Write 0x20000 be=0xF wdata=0x41 -> only device_req[1]=1, wdata/be forwarded,
//   rvalid next cycle.
// - Access 0x40000 (unmapped) -> gnt=1, no device_req, next cycle rvalid=1, err=1, rdata=0.
// - 2 hosts request together -> host0 gnt=1, host1 gnt=0; host1 granted the next cycle.
//   Responses go only to the matching host.
// - Back-to-back reads to RAM then Timer -> two responses on consecutive cycles, each routed
//   from the correct device; a timer err=1 propagates.
// - Assert rst_ni low the cycle after a grant -> no rvalid; all outputs return to reset values.

Source files
------------

// File: rtl/simple_bus_xbar.sv
// -----------------------------------------------------------------------------
// simple_bus_xbar
//
// Single-cycle, address-decoded interconnect between NrHosts bus hosts and
// NrDevices memory-mapped devices. Each cycle it:
//   1. arbitrates among the requesting hosts by fixed priority (lowest index wins),
//   2. decodes the winner's address against runtime base/mask registers,
//   3. forwards the winner's request fields to every device port and raises
//      device_req_o only for the decoded device.
// Devices answer exactly one cycle after their request. The routing decision
// is registered so that the response can be steered back to the host that
// issued it. An address that matches no device still gets a grant, and the
// crossbar itself answers the next cycle with an error response.
//
// Ports (arrays are unpacked [NrHosts] / [NrDevices]):
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   host_req_i                host request
//   host_gnt_o                grant, combinational in the request cycle
//   host_addr_i               byte address
//   host_we_i                 1 = write
//   host_be_i                 byte enables (DataWidth/8)
//   host_wdata_i              write data
//   host_rvalid_o             response valid (cycle after the grant)
//   host_rdata_o              response read data ('0 when not addressed)
//   host_err_o                response error
//   device_req_o              request to the decoded device
//   device_addr_o             forwarded address (all devices)
//   device_we_o               forwarded write enable (all devices)
//   device_be_o               forwarded byte enables (all devices)
//   device_wdata_o            forwarded write data (all devices)
//   device_rvalid_i           device response valid
//   device_rdata_i            device read data
//   device_err_i              device error
//   cfg_device_addr_base      per-device base address
//   cfg_device_addr_mask      per-device address mask
// -----------------------------------------------------------------------------
module simple_bus_xbar #(
    parameter int NrDevices    = 1,
    parameter int NrHosts      = 1,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    // Host side
    input  logic                      host_req_i           [NrHosts],
    output logic                      host_gnt_o           [NrHosts],
    input  logic [AddressWidth-1:0]   host_addr_i          [NrHosts],
    input  logic                      host_we_i            [NrHosts],
    input  logic [DataWidth/8-1:0]    host_be_i            [NrHosts],
    input  logic [DataWidth-1:0]      host_wdata_i         [NrHosts],
    output logic                      host_rvalid_o        [NrHosts],
    output logic [DataWidth-1:0]      host_rdata_o         [NrHosts],
    output logic                      host_err_o           [NrHosts],

    // Device side
    output logic                      device_req_o         [NrDevices],
    output logic [AddressWidth-1:0]   device_addr_o        [NrDevices],
    output logic                      device_we_o          [NrDevices],
    output logic [DataWidth/8-1:0]    device_be_o          [NrDevices],
    output logic [DataWidth-1:0]      device_wdata_o       [NrDevices],
    input  logic                      device_rvalid_i      [NrDevices],
    input  logic [DataWidth-1:0]      device_rdata_i       [NrDevices],
    input  logic                      device_err_i         [NrDevices],

    // Address map
    input  logic [AddressWidth-1:0]   cfg_device_addr_base [NrDevices],
    input  logic [AddressWidth-1:0]   cfg_device_addr_mask [NrDevices]
);

    localparam int BeWidth  = DataWidth / 8;
    // Select registers are at least one bit wide so a 1x1 crossbar still elaborates.
    localparam int HostSelW = (NrHosts   > 1) ? $clog2(NrHosts)   : 1;
    localparam int DevSelW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;

    // -------------------------------------------------------------------------
    // Arbitration: fixed priority, lowest index wins.
    // The loop walks from the highest index downwards so that the last
    // assignment made (the lowest requesting index) is the one that sticks.
    // The winner's request fields are picked up in the same loop, which avoids
    // indexing the host arrays with a possibly out-of-range select value.
    // -------------------------------------------------------------------------
    logic                    any_req;
    logic [HostSelW-1:0]     win_host;
    logic [AddressWidth-1:0] fwd_addr;
    logic                    fwd_we;
    logic [BeWidth-1:0]      fwd_be;
    logic [DataWidth-1:0]    fwd_wdata;

    always_comb begin
        any_req   = 1'b0;
        win_host  = '0;
        fwd_addr  = '0;
        fwd_we    = 1'b0;
        fwd_be    = '0;
        fwd_wdata = '0;
        for (int i = NrHosts - 1; i >= 0; i--) begin
            if (host_req_i[i]) begin
                any_req   = 1'b1;
                win_host  = HostSelW'(i);
                fwd_addr  = host_addr_i[i];
                fwd_we    = host_we_i[i];
                fwd_be    = host_be_i[i];
                fwd_wdata = host_wdata_i[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Address decode: device d matches when (addr & mask) == base.
    // Overlapping windows resolve to the lowest matching device index, again by
    // scanning downwards and letting the lowest match overwrite.
    // -------------------------------------------------------------------------
    logic               dev_hit;
    logic [DevSelW-1:0] dev_idx;

    always_comb begin
        dev_hit = 1'b0;
        dev_idx = '0;
        for (int d = NrDevices - 1; d >= 0; d--) begin
            if ((fwd_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) begin
                dev_hit = 1'b1;
                dev_idx = DevSelW'(d);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Grants: there is no back-pressure, so the arbitration winner is always
    // granted in the request cycle, mapped or not.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < NrHosts; gi++) begin : g_host_gnt
        assign host_gnt_o[gi] = any_req && (win_host == HostSelW'(gi));
    end

    // -------------------------------------------------------------------------
    // Forwarding: request fields are broadcast; only the request strobe is
    // steered, so a device only acts on the cycle it is actually addressed.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < NrDevices; gi++) begin : g_dev_fwd
        assign device_req_o[gi]   = any_req && dev_hit && (dev_idx == DevSelW'(gi));
        assign device_addr_o[gi]  = fwd_addr;
        assign device_we_o[gi]    = fwd_we;
        assign device_be_o[gi]    = fwd_be;
        assign device_wdata_o[gi] = fwd_wdata;
    end

    // -------------------------------------------------------------------------
    // Response routing state. Captured on every grant; pending_reg follows
    // any_req every cycle, so back-to-back grants each produce exactly one
    // response in the following cycle. An asynchronous reset clears
    // pending_reg, which drops any response in flight.
    // -------------------------------------------------------------------------
    logic                pending_reg;
    logic                unmapped_reg;
    logic [HostSelW-1:0] host_sel_reg;
    logic [DevSelW-1:0]  dev_sel_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_reg  <= 1'b0;
            unmapped_reg <= 1'b0;
            host_sel_reg <= '0;
            dev_sel_reg  <= '0;
        end else begin
            pending_reg <= any_req;
            if (any_req) begin
                host_sel_reg <= win_host;
                dev_sel_reg  <= dev_idx;
                unmapped_reg <= !dev_hit;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Response mux: select the registered device's response combinationally.
    // -------------------------------------------------------------------------
    logic                 dev_rvalid;
    logic                 dev_err;
    logic [DataWidth-1:0] dev_rdata;

    always_comb begin
        dev_rvalid = 1'b0;
        dev_err    = 1'b0;
        dev_rdata  = '0;
        for (int d = 0; d < NrDevices; d++) begin
            if (dev_sel_reg == DevSelW'(d)) begin
                dev_rvalid = device_rvalid_i[d];
                dev_err    = device_err_i[d];
                dev_rdata  = device_rdata_i[d];
            end
        end
    end

    // An unmapped access is answered by the crossbar itself: valid, error,
    // zero data. Everything is qualified by pending_reg so stale device
    // outputs can never reach a host outside a response cycle (e.g. after reset).
    logic                 rsp_valid;
    logic                 rsp_err;
    logic [DataWidth-1:0] rsp_rdata;

    always_comb begin
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        if (pending_reg) begin
            if (unmapped_reg) begin
                rsp_valid = 1'b1;
                rsp_err   = 1'b1;
            end else begin
                rsp_valid = dev_rvalid;
                rsp_err   = dev_err;
                rsp_rdata = dev_rdata;
            end
        end
    end

    // Only the host that owns the outstanding response sees it; all other
    // hosts see an idle, all-zero response.
    for (genvar gi = 0; gi < NrHosts; gi++) begin : g_host_rsp
        logic sel;
        assign sel                = (host_sel_reg == HostSelW'(gi));
        assign host_rvalid_o[gi]  = sel && rsp_valid;
        assign host_err_o[gi]     = sel && rsp_err;
        assign host_rdata_o[gi]   = sel ? rsp_rdata : '0;
    end

endmodule

// File: tb/tb_simple_bus_xbar.sv
// -----------------------------------------------------------------------------
// Testbench for simple_bus_xbar: 2 hosts, 3 devices (RAM, SimCtrl, Timer).
// A reference model computes grants, decode and the expected response of each
// cycle from the arbitration/decode rules; a device model answers every device
// request one cycle later with data chosen in advance by the bench.
// -----------------------------------------------------------------------------
module tb_simple_bus_xbar;

    localparam int H  = 2;
    localparam int D  = 3;
    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;

    logic          host_req    [H];
    logic          host_gnt    [H];
    logic [AW-1:0] host_addr   [H];
    logic          host_we     [H];
    logic [3:0]    host_be     [H];
    logic [DW-1:0] host_wdata  [H];
    logic          host_rvalid [H];
    logic [DW-1:0] host_rdata  [H];
    logic          host_err    [H];

    logic          dev_req     [D];
    logic [AW-1:0] dev_addr    [D];
    logic          dev_we      [D];
    logic [3:0]    dev_be      [D];
    logic [DW-1:0] dev_wdata   [D];
    logic          dev_rvalid  [D];
    logic [DW-1:0] dev_rdata   [D];
    logic          dev_err     [D];
    logic [AW-1:0] cfg_base    [D];
    logic [AW-1:0] cfg_mask    [D];

    int pass_cnt  = 0;
    int total_cnt = 0;

    simple_bus_xbar #(
        .NrDevices   (D),
        .NrHosts     (H),
        .DataWidth   (DW),
        .AddressWidth(AW)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .host_req_i          (host_req),
        .host_gnt_o          (host_gnt),
        .host_addr_i         (host_addr),
        .host_we_i           (host_we),
        .host_be_i           (host_be),
        .host_wdata_i        (host_wdata),
        .host_rvalid_o       (host_rvalid),
        .host_rdata_o        (host_rdata),
        .host_err_o          (host_err),
        .device_req_o        (dev_req),
        .device_addr_o       (dev_addr),
        .device_we_o         (dev_we),
        .device_be_o         (dev_be),
        .device_wdata_o      (dev_wdata),
        .device_rvalid_i     (dev_rvalid),
        .device_rdata_i      (dev_rdata),
        .device_err_i        (dev_err),
        .cfg_device_addr_base(cfg_base),
        .cfg_device_addr_mask(cfg_mask)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model state ----------------
    int            win;           // winning host, -1 = none
    int            win_dev;       // decoded device, -1 = unmapped
    logic          exp_gnt  [H];
    logic          exp_dreq [D];
    logic          exp_rv   [H];
    logic [DW-1:0] exp_rd   [H];
    logic          exp_er   [H];
    logic          pend_valid;
    int            pend_host;
    logic          pend_unmapped;
    logic [DW-1:0] pend_rdata;
    logic          pend_err;
    logic [DW-1:0] nxt_rdata [D]; // data each device will return next cycle
    logic          nxt_err   [D];

    // Let inputs settle, then derive this cycle's expectations from the rules.
    task automatic model_settle();
        #1;
        win = -1;
        for (int h = 0; h < H; h++) if (host_req[h] && win < 0) win = h;
        win_dev = -1;
        if (win >= 0)
            for (int d = 0; d < D; d++)
                if (win_dev < 0 && (host_addr[win] & cfg_mask[d]) == cfg_base[d]) win_dev = d;
        for (int h = 0; h < H; h++) exp_gnt[h] = (h == win);
        for (int d = 0; d < D; d++) exp_dreq[d] = (win >= 0) && (d == win_dev);
        for (int h = 0; h < H; h++) begin
            exp_rv[h] = 1'b0; exp_rd[h] = '0; exp_er[h] = 1'b0;
            if (pend_valid && h == pend_host) begin
                exp_rv[h] = 1'b1;
                exp_rd[h] = pend_unmapped ? '0 : pend_rdata;
                exp_er[h] = pend_unmapped ? 1'b1 : pend_err;
            end
        end
    endtask

    // Record the outstanding response, clock once, then let the device model
    // answer whatever the DUT requested in the previous cycle.
    task automatic advance();
        logic seen [D];
        for (int d = 0; d < D; d++) seen[d] = dev_req[d];
        pend_valid    = (win >= 0);
        pend_host     = win;
        pend_unmapped = (win_dev < 0);
        if (win_dev >= 0) begin
            pend_rdata = nxt_rdata[win_dev];
            pend_err   = nxt_err[win_dev];
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < D; d++) begin
            dev_rvalid[d] = seen[d];
            dev_rdata[d]  = nxt_rdata[d];
            dev_err[d]    = nxt_err[d];
            nxt_rdata[d]  = $urandom;
            nxt_err[d]    = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic idle_hosts();
        for (int h = 0; h < H; h++) begin
            host_req[h] = 1'b0; host_addr[h] = '0; host_we[h] = 1'b0;
            host_be[h] = '0; host_wdata[h] = '0;
        end
    endtask

    task automatic set_host(input int h, input logic [AW-1:0] a, input logic we,
                            input logic [3:0] be, input logic [DW-1:0] wd);
        host_req[h] = 1'b1; host_addr[h] = a; host_we[h] = we;
        host_be[h] = be; host_wdata[h] = wd;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        idle_hosts();
        for (int d = 0; d < D; d++) begin
            dev_rvalid[d] = 1'b1; dev_rdata[d] = 32'hFFFF_FFFF; dev_err[d] = 1'b1;
            nxt_rdata[d] = $urandom; nxt_err[d] = 1'b0;
        end
        pend_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        for (int h = 0; h < H; h++) begin
            total_cnt++;
            if (host_rvalid[h] !== 1'b0 || host_err[h] !== 1'b0 || host_rdata[h] !== '0)
                $display("FAIL reset_rsp h%0d: rvalid=%b err=%b rdata=%h required 0/0/0",
                         h, host_rvalid[h], host_err[h], host_rdata[h]);
            else pass_cnt++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int d = 0; d < D; d++) dev_rvalid[d] = 1'b0;
        model_settle();
        for (int h = 0; h < H; h++) begin
            total_cnt++;
            if (host_rvalid[h] !== 1'b0 || host_gnt[h] !== 1'b0)
                $display("FAIL after_reset h%0d: rvalid=%b gnt=%b required 0/0", h, host_rvalid[h], host_gnt[h]);
            else pass_cnt++;
        end
        advance();
        $display("reset: outputs idle");
    endtask

    task automatic test_read();
        idle_hosts();
        set_host(0, 32'h0010_0004, 1'b0, 4'hF, '0);
        nxt_rdata[0] = 32'hDEAD_BEEF; nxt_err[0] = 1'b0;
        model_settle();
        total_cnt++;
        if (host_gnt[0] !== 1'b1 || host_gnt[1] !== 1'b0)
            $display("FAIL read_gnt: gnt=%b%b required 01", host_gnt[1], host_gnt[0]);
        else pass_cnt++;
        total_cnt++;
        if (dev_req[0] !== 1'b1 || dev_req[1] !== 1'b0 || dev_req[2] !== 1'b0 || dev_addr[0] !== 32'h0010_0004)
            $display("FAIL read_dreq: req=%b%b%b addr=%h required 001 00100004",
                     dev_req[2], dev_req[1], dev_req[0], dev_addr[0]);
        else pass_cnt++;
        advance();
        idle_hosts();
        model_settle();
        total_cnt++;
        if (host_rvalid[0] !== 1'b1 || host_rdata[0] !== 32'hDEAD_BEEF || host_err[0] !== 1'b0 || host_rvalid[1] !== 1'b0)
            $display("FAIL read_rsp: rvalid=%b rdata=%h err=%b h1rvalid=%b required 1 deadbeef 0 0",
                     host_rvalid[0], host_rdata[0], host_err[0], host_rvalid[1]);
        else pass_cnt++;
        advance();
        $display("read: host0 0x00100004 -> %h", 32'hDEAD_BEEF);
    endtask

    task automatic test_write();
        idle_hosts();
        set_host(1, 32'h0002_0000, 1'b1, 4'hF, 32'h41);
        nxt_err[1] = 1'b0;
        model_settle();
        total_cnt++;
        if (host_gnt[1] !== 1'b1 || host_gnt[0] !== 1'b0)
            $display("FAIL write_gnt: gnt=%b%b required 10", host_gnt[1], host_gnt[0]);
        else pass_cnt++;
        total_cnt++;
        if (dev_req[0] !== 1'b0 || dev_req[1] !== 1'b1 || dev_req[2] !== 1'b0)
            $display("FAIL write_dreq: req=%b%b%b required 010", dev_req[2], dev_req[1], dev_req[0]);
        else pass_cnt++;
        total_cnt++;
        if (dev_wdata[1] !== 32'h41 || dev_be[1] !== 4'hF || dev_we[1] !== 1'b1)
            $display("FAIL write_fwd: wdata=%h be=%h we=%b required 00000041 f 1", dev_wdata[1], dev_be[1], dev_we[1]);
        else pass_cnt++;
        advance();
        idle_hosts();
        model_settle();
        total_cnt++;
        if (host_rvalid[1] !== 1'b1 || host_err[1] !== 1'b0 || host_rvalid[0] !== 1'b0)
            $display("FAIL write_rsp: h1rvalid=%b h1err=%b h0rvalid=%b required 1 0 0",
                     host_rvalid[1], host_err[1], host_rvalid[0]);
        else pass_cnt++;
        advance();
        $display("write: host1 0x00020000 <- 00000041");
    endtask

    task automatic test_unmapped();
        idle_hosts();
        set_host(0, 32'h0004_0000, 1'b0, 4'hF, '0);
        model_settle();
        total_cnt++;
        if (host_gnt[0] !== 1'b1 || dev_req[0] !== 1'b0 || dev_req[1] !== 1'b0 || dev_req[2] !== 1'b0)
            $display("FAIL unmapped_req: gnt=%b dreq=%b%b%b required 1 000",
                     host_gnt[0], dev_req[2], dev_req[1], dev_req[0]);
        else pass_cnt++;
        advance();
        idle_hosts();
        model_settle();
        total_cnt++;
        if (host_rvalid[0] !== 1'b1 || host_err[0] !== 1'b1 || host_rdata[0] !== '0)
            $display("FAIL unmapped_rsp: rvalid=%b err=%b rdata=%h required 1 1 0",
                     host_rvalid[0], host_err[0], host_rdata[0]);
        else pass_cnt++;
        advance();
        $display("unmapped: host0 0x00040000 -> err");
    endtask

    task automatic test_contention();
        idle_hosts();
        set_host(0, 32'h0010_0010, 1'b0, 4'hF, '0);
        set_host(1, 32'h0003_0004, 1'b0, 4'hF, '0);
        nxt_rdata[0] = 32'h1111_0000; nxt_err[0] = 1'b0;
        model_settle();
        total_cnt++;
        if (host_gnt[0] !== 1'b1 || host_gnt[1] !== 1'b0 || dev_req[0] !== 1'b1 || dev_req[2] !== 1'b0)
            $display("FAIL contend_gnt: gnt=%b%b dreq0=%b dreq2=%b required 01 1 0",
                     host_gnt[1], host_gnt[0], dev_req[0], dev_req[2]);
        else pass_cnt++;
        advance();
        host_req[0] = 1'b0;
        nxt_rdata[2] = 32'h2222_0000; nxt_err[2] = 1'b0;
        model_settle();
        total_cnt++;
        if (host_gnt[1] !== 1'b1 || dev_req[2] !== 1'b1)
            $display("FAIL contend_second: gnt1=%b dreq2=%b required 1 1", host_gnt[1], dev_req[2]);
        else pass_cnt++;
        total_cnt++;
        if (host_rvalid[0] !== 1'b1 || host_rdata[0] !== 32'h1111_0000 || host_rvalid[1] !== 1'b0 || host_rdata[1] !== '0)
            $display("FAIL contend_rsp0: h0 rvalid=%b rdata=%h h1 rvalid=%b rdata=%h required 1 11110000 0 0",
                     host_rvalid[0], host_rdata[0], host_rvalid[1], host_rdata[1]);
        else pass_cnt++;
        advance();
        idle_hosts();
        model_settle();
        total_cnt++;
        if (host_rvalid[1] !== 1'b1 || host_rdata[1] !== 32'h2222_0000 || host_rvalid[0] !== 1'b0)
            $display("FAIL contend_rsp1: h1 rvalid=%b rdata=%h h0 rvalid=%b required 1 22220000 0",
                     host_rvalid[1], host_rdata[1], host_rvalid[0]);
        else pass_cnt++;
        advance();
        $display("contention: host0 then host1 served");
    endtask

    task automatic test_back_to_back();
        idle_hosts();
        set_host(0, 32'h0010_0020, 1'b0, 4'hF, '0);
        nxt_rdata[0] = 32'hA5A5_0001; nxt_err[0] = 1'b0;
        model_settle();
        advance();
        set_host(0, 32'h0003_0008, 1'b0, 4'hF, '0);
        nxt_rdata[2] = 32'h5A5A_0002; nxt_err[2] = 1'b1;
        model_settle();
        total_cnt++;
        if (dev_req[2] !== 1'b1 || host_rvalid[0] !== 1'b1 || host_rdata[0] !== 32'hA5A5_0001 || host_err[0] !== 1'b0)
            $display("FAIL b2b_first: dreq2=%b rvalid=%b rdata=%h err=%b required 1 1 a5a50001 0",
                     dev_req[2], host_rvalid[0], host_rdata[0], host_err[0]);
        else pass_cnt++;
        advance();
        idle_hosts();
        model_settle();
        total_cnt++;
        if (host_rvalid[0] !== 1'b1 || host_rdata[0] !== 32'h5A5A_0002 || host_err[0] !== 1'b1)
            $display("FAIL b2b_second: rvalid=%b rdata=%h err=%b required 1 5a5a0002 1",
                     host_rvalid[0], host_rdata[0], host_err[0]);
        else pass_cnt++;
        advance();
        $display("back_to_back: RAM then Timer(err)");
    endtask

    task automatic test_reset_mid();
        idle_hosts();
        set_host(0, 32'h0010_0000, 1'b0, 4'hF, '0);
        nxt_err[0] = 1'b0;
        model_settle();
        advance();              // device 0 now drives rvalid=1
        idle_hosts();
        rst_n = 1'b0;
        pend_valid = 1'b0;      // reset drops the in-flight response
        #1;
        for (int h = 0; h < H; h++) begin
            total_cnt++;
            if (host_rvalid[h] !== 1'b0 || host_err[h] !== 1'b0 || host_rdata[h] !== '0)
                $display("FAIL reset_mid h%0d: rvalid=%b err=%b rdata=%h required 0/0/0",
                         h, host_rvalid[h], host_err[h], host_rdata[h]);
            else pass_cnt++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_settle();
        total_cnt++;
        if (host_rvalid[0] !== 1'b0 || host_rdata[0] !== '0)
            $display("FAIL reset_mid_after: rvalid=%b rdata=%h required 0 0", host_rvalid[0], host_rdata[0]);
        else pass_cnt++;
        advance();
        $display("reset_mid: response dropped");
    endtask

    task automatic test_random();
        int errs;
        for (int n = 0; n < 300; n++) begin
            idle_hosts();
            for (int h = 0; h < H; h++) begin
                logic [AW-1:0] a;
                case ($urandom_range(0, 4))
                    0:       a = 32'h0010_0000 | ($urandom & 32'h000F_FFFC);
                    1:       a = 32'h0002_0000 | ($urandom & 32'h0000_03FC);
                    2:       a = 32'h0003_0000 | ($urandom & 32'h0000_03FC);
                    3:       a = 32'h0004_0000;
                    default: a = $urandom;
                endcase
                if ($urandom_range(0, 2) != 0)
                    set_host(h, a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
            end
            model_settle();
            errs = 0;
            for (int h = 0; h < H; h++) begin
                total_cnt++;
                if (host_gnt[h] !== exp_gnt[h] || host_rvalid[h] !== exp_rv[h] ||
                    host_rdata[h] !== exp_rd[h] || host_err[h] !== exp_er[h]) begin
                    $display("FAIL rand%0d_host%0d: gnt=%b rv=%b rd=%h er=%b required %b %b %h %b",
                             n, h, host_gnt[h], host_rvalid[h], host_rdata[h], host_err[h],
                             exp_gnt[h], exp_rv[h], exp_rd[h], exp_er[h]);
                    errs++;
                end else pass_cnt++;
            end
            for (int d = 0; d < D; d++) begin
                total_cnt++;
                if (dev_req[d] !== exp_dreq[d] ||
                    (win >= 0 && (dev_addr[d] !== host_addr[win] || dev_we[d] !== host_we[win] ||
                                  dev_be[d] !== host_be[win] || dev_wdata[d] !== host_wdata[win]))) begin
                    $display("FAIL rand%0d_dev%0d: req=%b addr=%h required req=%b addr=%h",
                             n, d, dev_req[d], dev_addr[d], exp_dreq[d],
                             (win >= 0) ? host_addr[win] : '0);
                    errs++;
                end else pass_cnt++;
            end
            $display("rand %0d: win=%0d dev=%0d errs=%0d", n, win, win_dev, errs);
            advance();
        end
    endtask

    initial begin
        idle_hosts();
        cfg_base[0] = 32'h0010_0000; cfg_mask[0] = ~32'h000F_FFFF;
        cfg_base[1] = 32'h0002_0000; cfg_mask[1] = ~32'h0000_03FF;
        cfg_base[2] = 32'h0003_0000; cfg_mask[2] = ~32'h0000_03FF;
        test_reset();
        test_read();
        test_write();
        test_unmapped();
        test_contention();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
